mem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single 128-bit main-memory port between the instruction cache (port I, read-only) and the data cache (port D, read/write).
- Sits between the cache refill/write-back interfaces and main memory.
- Uses registered round-robin grant, grant lock until completion, per-port ready routing, a watchdog timeout, and grant statistics counters.

---
 rtl/mem_arbiter.sv | 71 +++++++
 tb/tb_mem_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory line port between I-cache and D-cache
module mem_arbiter #(
  parameter int WIDTH = 32,
  parameter int LINE = 128,
  parameter int TIMEOUT = 256,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic             i_ready,
  output logic [LINE-1:0]  i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [LINE-1:0]  d_wdata,
  output logic             d_ready,
  output logic [LINE-1:0]  d_rdata,
  output logic             mem_req,
  output logic             WriteEnable,
  output logic [WIDTH-1:0] memory_address,
  output logic [LINE-1:0]  mem_writedata,
  input  logic [LINE-1:0]  mem_readdata,
  input  logic             mem_ready,
  output logic             timeout_err,
  output logic [CNT_W-1:0] i_grants,
  output logic [CNT_W-1:0] d_grants
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] TO = WD_W'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
  state_t state, state_n;
  logic last_d;
  logic [WD_W-1:0] wd, wd_inc;
  assign wd_inc = wd + WD_W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // on a tie, I wins unless it was the last port served
  always_comb
    state_n = state == IDLE ? (i_req && (!d_req || last_d) ? GNT_I : d_req ? GNT_D : IDLE)
            : mem_ready ? IDLE : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_d <= 1'b1;
      wd <= '0;
      timeout_err <= 1'b0;
      i_grants <= '0;
      d_grants <= '0;
    end else if (state == IDLE) begin
      wd <= '0;
    end else if (mem_ready) begin
      last_d <= state == GNT_D;
      if (state == GNT_I) i_grants <= i_grants + CNT_W'(1);
      if (state == GNT_D) d_grants <= d_grants + CNT_W'(1);
    end else begin
      if (wd != TO) wd <= wd_inc;
      if (wd_inc == TO) timeout_err <= 1'b1;
    end
  always_comb begin
    mem_req = state != IDLE;
    WriteEnable = state == GNT_D && d_we;
    memory_address = state == GNT_I ? i_addr : state == GNT_D ? d_addr : '0;
    mem_writedata = state == GNT_D ? d_wdata : '0;
    i_ready = state == GNT_I && mem_ready;
    i_rdata = state == GNT_I ? mem_readdata : '0;
    d_ready = state == GNT_D && mem_ready;
    d_rdata = state == GNT_D ? mem_readdata : '0;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_req = 0, d_req = 0, d_we = 0, mem_ready = 0;
  logic [31:0] i_addr = 0, d_addr = 0;
  logic [127:0] d_wdata = 0, mem_readdata = 0;
  logic i_ready, d_ready, mem_req, WriteEnable, timeout_err;
  logic [127:0] i_rdata, d_rdata, mem_writedata;
  logic [31:0] memory_address, i_grants, d_grants;

  mem_arbiter #(.WIDTH(32), .LINE(128), .TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .WriteEnable(WriteEnable), .memory_address(memory_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_ready(mem_ready),
    .timeout_err(timeout_err), .i_grants(i_grants), .d_grants(d_grants)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  // model: owner 0 = none, 1 = I, 2 = D
  int m_g, m_last, m_ic, m_dc, m_wd, gcyc, dly;
  bit m_err, rnd, rearm_i, rearm_d, done_i, done_d, started;

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_g = 0; m_last = 2; m_ic = 0; m_dc = 0; m_wd = 0; m_err = 0; gcyc = 0;
  endtask

  task automatic check_all();
    chk("mem_req", mem_req, m_g != 0);
    chk("we", WriteEnable, m_g == 2 && d_we);
    chk("addr", memory_address, m_g == 1 ? i_addr : m_g == 2 ? d_addr : 32'h0);
    chk("wdata", mem_writedata, m_g == 2 ? d_wdata : 128'h0);
    chk("i_ready", i_ready, m_g == 1 && mem_ready);
    chk("i_rdata", i_rdata, m_g == 1 ? mem_readdata : 128'h0);
    chk("d_ready", d_ready, m_g == 2 && mem_ready);
    chk("d_rdata", d_rdata, m_g == 2 ? mem_readdata : 128'h0);
    chk("timeout_err", timeout_err, m_err);
    chk("i_grants", i_grants, m_ic);
    chk("d_grants", d_grants, m_dc);
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    done_i = 0; done_d = 0; started = 0;
    if (m_g == 0) begin
      if (i_req && d_req) m_g = 3 - m_last;
      else m_g = i_req ? 1 : d_req ? 2 : 0;
      started = m_g != 0;
      m_wd = 0;
    end else if (mem_ready) begin
      m_last = m_g;
      if (m_g == 1) begin m_ic++; done_i = 1; end
      else begin m_dc++; done_d = 1; end
      m_g = 0;
    end else begin
      m_wd++;
      if (m_wd >= TO) m_err = 1;
    end
    #1;
    if (done_i) begin
      i_req = rnd ? 1'($urandom % 2) : rearm_i;
      if (i_req) i_addr = {$urandom, 4'h0};
    end
    if (done_d) begin
      d_req = rnd ? 1'($urandom % 2) : rearm_d;
      if (d_req) begin d_addr = {$urandom, 4'h0}; d_we = 1'($urandom); d_wdata = r128(); end
    end
    if (rnd) begin
      if (!i_req && !done_i && $urandom % 3 == 0) begin i_req = 1; i_addr = {$urandom, 4'h0}; end
      if (!d_req && !done_d && $urandom % 3 == 0) begin
        d_req = 1; d_addr = {$urandom, 4'h0}; d_we = 1'($urandom); d_wdata = r128();
      end
      mem_readdata = r128();
      if (started) dly = $urandom_range(0, 5);
    end
    if (started) gcyc = 0;
    else if (m_g != 0) gcyc++;
    mem_ready = m_g != 0 ? gcyc >= dly : rnd && $urandom % 6 == 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; i_req = 0; d_req = 0; mem_ready = 0;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    rnd = 0; rearm_i = 0; rearm_d = 0; dly = 0;
    model_reset();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1 rst = 0;
    // I-only refill
    i_req = 1; i_addr = 32'h0000_1000; dly = 3; mem_readdata = {16{8'hA5}};
    repeat (7) step();
    chk("i_only_grants", i_grants, 1);
    // simultaneous after reset: I first, then D
    do_reset();
    i_req = 1; d_req = 1; d_we = 0; i_addr = 32'h40; d_addr = 32'h80; dly = 1;
    mem_readdata = 128'h5A5A;
    repeat (10) step();
    chk("simul_i", i_grants, 1);
    chk("simul_d", d_grants, 1);
    // D write-back
    d_req = 1; d_we = 1; d_addr = 32'h0000_2040;
    d_wdata = 128'h0123456789ABCDEF0123456789ABCDEF; dly = 2;
    repeat (6) step();
    chk("wb_d", d_grants, 2);
    // fairness with both continuously requesting
    do_reset();
    rearm_i = 1; rearm_d = 1; i_req = 1; d_req = 1; d_we = 0; dly = 0;
    for (int n = 0; n < 100 && m_ic + m_dc < 6; n++) step();
    rearm_i = 0; rearm_d = 0; i_req = 0; d_req = 0;
    chk("fair_i", i_grants, 3);
    chk("fair_d", d_grants, 3);
    step();
    // watchdog: ready withheld past TIMEOUT
    do_reset();
    d_req = 1; d_we = 0; d_addr = 32'h300; dly = 10;
    repeat (14) step();
    chk("wdog_err", timeout_err, 1);
    chk("wdog_d", d_grants, 1);
    // randomized traffic
    do_reset();
    rnd = 1;
    repeat (400) step();
    rnd = 0; dly = 1;
    for (int n = 0; n < 30; n++) begin
      step();
      if (m_g == 0) begin i_req = 0; d_req = 0; mem_ready = 0; end
    end
    // async reset in the middle of a D grant
    d_req = 1; d_we = 1; d_addr = 32'h500; d_wdata = r128(); dly = 100;
    repeat (3) step();
    @(negedge clk);
    mem_ready = 1;
    #1 chk("pre_rst_d_ready", d_ready, 1);
    rst = 1;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 rst = 0; d_req = 0; mem_ready = 0;
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
